bgp_enable_sequencer: RTL
=========================

// Module: bgp_enable_sequencer
// PURPOSE
//  Power-up sequencer and shared-enable arbiter for the avsdbgp_3v3_sky130_v2 bandgap in the user area.
//  Several digital requesters share one reference. The block ORs their requests and drives the bandgap EN.
//  It waits a fixed settle time before declaring VBGP valid, grants requesters only while the reference is valid,
//  and holds the bandgap on for a hold-off window after the last request drops.
// PARAMETERS
//  NREQ           4    number of requesters (1..16)
//  SETTLE_CYCLES  1000 clocks from EN rise to VBGP valid (>=1)
//  HOLDOFF_CYCLES 64   clocks EN stays high after last request drops (>=1)
//  TIMEOUT_CYCLES 4096 extra clocks to wait for bgp_ok_i (BGP_OK_CHECK_EN only, >=1)
//  CNT_W          16   counter width; must hold max(SETTLE,HOLDOFF,TIMEOUT)-1
// PORTS
//  wb_clk_i     in  1    single clock
//  wb_rst_ni    in  1    asynchronous active-low reset
//  req_i        in  NREQ per-requester enable request, level
//  force_off_i  in  1    management override: force bandgap off, clear fault
//  bgp_ok_i     in  1    analog comparator "VBGP in range" (used only with BGP_OK_CHECK_EN)
//  bgp_en_o     out 1    drives bandgap EN
//  bgp_ready_o  out 1    VBGP valid
//  grant_o      out NREQ per-requester grant
//  state_o      out 3    current FSM state encoding (debug / LA)
//  fault_o      out 1    sticky startup fault (0 without BGP_OK_CHECK_EN)
// BEHAVIOUR
//  Reset (async assert, sync release): state=OFF; cnt=0; bgp_en_o=0, bgp_ready_o=0, grant_o=0, fault_o=0.
//  All outputs are registered. any_req = |req_i.
//  States (state_o): OFF=0, STARTUP=1, ON=2, HOLDOFF=3, WAIT_OK=4, FAULT=5.
//  OFF: en=0, ready=0. When any_req & !force_off_i: go to STARTUP and load cnt=SETTLE_CYCLES-1.
//  STARTUP: en=1, ready=0, cnt decrements every clock.
//    !any_req -> OFF (abort; no hold-off).
//    cnt==0 -> ON (or WAIT_OK when the macro is defined).
//    bgp_en_o rises the clock after the OFF->STARTUP edge.
//    bgp_ready_o rises exactly SETTLE_CYCLES clocks after bgp_en_o rises.
//  ON: en=1, ready=1. grant_o <= req_i each clock, so grants lag req_i by 1 clock.
//    !any_req -> HOLDOFF and load cnt=HOLDOFF_CYCLES-1.
//  HOLDOFF: en=1, ready=1, grant_o=0, cnt decrements.
//    any_req -> ON immediately, with no re-settle; grant follows next clock.
//    cnt==0 & !any_req -> OFF.
//  force_off_i: highest priority, from any state. Next clock: state=OFF, en/ready/grant=0, fault_o cleared.
//    The block stays in OFF while force_off_i is held, even with requests pending.
//  grant_o is always 0 outside ON; grant_o[i] is never 1 while bgp_ready_o is 0.
//  Simultaneous events:
//    force_off_i beats req_i.
//    In HOLDOFF, a req arriving in the same clock as cnt==0 wins: the next state is ON.
//  Counters saturate at 0 and never wrap.
// CONFIGURATION
//  BGP_OK_CHECK_EN defined:
//    STARTUP cnt==0 -> WAIT_OK and load cnt=TIMEOUT_CYCLES-1.
//    WAIT_OK: en=1, ready=0. bgp_ok_i=1 -> ON. cnt==0 with bgp_ok_i=0 -> FAULT. !any_req -> OFF.
//    FAULT: en=0, ready=0, grant=0, fault_o=1. Sticky; exits to OFF only on force_off_i or reset.
//  BGP_OK_CHECK_EN undefined:
//    bgp_ok_i is ignored and fault_o is tied to 0.
//    WAIT_OK and FAULT are unreachable; STARTUP goes directly to ON.
// TESTING (SETTLE_CYCLES=8, HOLDOFF_CYCLES=4, TIMEOUT_CYCLES=6)
//  1 Reset, then req_i=0001 at cycle 0: en=1 at cycle 2, ready=1 at cycle 10, grant=0001 at cycle 11.
//  2 In ON, drop all reqs: en/ready stay 1 for 4 clocks, then OFF. Re-req at HOLDOFF clock 2: ON, no re-settle.
//  3 Drop req at STARTUP clock 3: OFF next clock, ready never rose, grant stays 0.
//  4 In ON with req=1010, pulse force_off_i: all outputs 0 next clock, stays OFF while asserted; req-held restart after release.
//  5 BGP_OK_CHECK_EN, bgp_ok_i=0: WAIT_OK for 6 clocks, then FAULT, fault_o=1, en=0; force_off_i clears fault_o.
//  6 Assert wb_rst_ni low mid-STARTUP and mid-ON: all outputs 0 immediately (async), FSM in OFF.

Source files
------------

// File: rtl/bgp_enable_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bgp_enable_sequencer
// Description : Power-up sequencer and shared-enable arbiter for the user-area
//               bandgap reference. ORs the requester enables and drives the
//               bandgap EN. Declares VBGP valid after a fixed settle time and
//               grants requesters only while the reference is valid. Keeps the
//               bandgap on for a hold-off window after the last request drops.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: BGP_OK_CHECK_EN
//   Defined   : after settling, wait up to TIMEOUT_CYCLES for bgp_ok_i; a
//               timeout enters a sticky FAULT state (fault_o=1, EN off).
//   Undefined : bgp_ok_i is ignored, fault_o is always 0.
// ----------------------------------------------------------------------------
// Ports:
//   wb_clk_i     in   1     clock
//   wb_rst_ni    in   1     asynchronous active-low reset
//   req_i        in   NREQ  per-requester enable request (level)
//   force_off_i  in   1     management override: force off, clear fault
//   bgp_ok_i     in   1     analog "VBGP in range" comparator
//   bgp_en_o     out  1     bandgap EN
//   bgp_ready_o  out  1     VBGP valid
//   grant_o      out  NREQ  per-requester grant
//   state_o      out  3     FSM state (OFF=0 STARTUP=1 ON=2 HOLDOFF=3
//                           WAIT_OK=4 FAULT=5)
//   fault_o      out  1     sticky startup fault
// ============================================================================
module bgp_enable_sequencer #(
    parameter int NREQ           = 4,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int HOLDOFF_CYCLES = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            force_off_i,
    input  logic            bgp_ok_i,
    output logic            bgp_en_o,
    output logic            bgp_ready_o,
    output logic [NREQ-1:0] grant_o,
    output logic [2:0]      state_o,
    output logic            fault_o
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STARTUP = 3'd1,
        ST_ON      = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_WAIT_OK = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              fault_q, fault_d;

    logic              any_req;
    logic              cnt_zero;
    logic [CNT_W-1:0]  cnt_dec;

    assign any_req  = |req_i;
    assign cnt_zero = (cnt_q == '0);
    // Saturating decrement: the counter parks at zero instead of wrapping.
    assign cnt_dec  = cnt_zero ? '0 : cnt_q - 1'b1;

`ifdef BGP_OK_CHECK_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`else
    // Keeps the comparator input and timeout parameter referenced when the
    // check is compiled out.
    logic [CNT_W:0] w_unused_cfg;
    assign w_unused_cfg = {bgp_ok_i, CNT_W'(TIMEOUT_CYCLES - 1)};
`endif

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            grant_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            grant_q <= grant_d;
            fault_q <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_OFF: begin
                if (any_req) begin
                    state_d = ST_STARTUP;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            ST_STARTUP: begin
                if (!any_req) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
`ifdef BGP_OK_CHECK_EN
                    state_d = ST_WAIT_OK;
                    cnt_d   = TIMEOUT_LOAD;
`else
                    state_d = ST_ON;
`endif
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_ON: begin
                if (!any_req) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = HOLDOFF_LOAD;
                end
            end
            ST_HOLDOFF: begin
                // A request in the final hold-off clock still wins.
                if (any_req) begin
                    state_d = ST_ON;
                end else if (cnt_zero) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
`ifdef BGP_OK_CHECK_EN
            ST_WAIT_OK: begin
                if (!any_req) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (bgp_ok_i) begin
                    state_d = ST_ON;
                end else if (cnt_zero) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
`endif
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // Outputs are a registered image of the current state.
        en_d    = (state_q == ST_STARTUP) || (state_q == ST_ON) ||
                  (state_q == ST_HOLDOFF) || (state_q == ST_WAIT_OK);
        ready_d = (state_q == ST_ON) || (state_q == ST_HOLDOFF);
        // Gating on ready_q guarantees a grant never precedes bgp_ready_o.
        grant_d = ((state_q == ST_ON) && ready_q) ? req_i : '0;
`ifdef BGP_OK_CHECK_EN
        fault_d = (state_q == ST_FAULT);
`else
        fault_d = 1'b0;
`endif

        // Management override beats everything, including pending requests.
        if (force_off_i) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            en_d    = 1'b0;
            ready_d = 1'b0;
            grant_d = '0;
            fault_d = 1'b0;
        end
    end

    assign bgp_en_o    = en_q;
    assign bgp_ready_o = ready_q;
    assign grant_o     = grant_q;
    assign state_o     = state_q;
    assign fault_o     = fault_q;

endmodule
`default_nettype wire
